// File: rtl/lsu.sv
// Memory-access stage: forwards ALU results and runs one req/ack memory transaction per load/store.
// Latency: 1 cycle for non-memory ops, at least 2 cycles from accept for loads/stores; in_ready is low while a request is outstanding.
module lsu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [14:0]     op_ir,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] rs2,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [7:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_data,
    output logic            out_rd_we,
    output logic [1:0]      out_exc
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_AMO   = 7'b0101111;

    state_t            state_q, state_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
    logic [7:0]        dmem_be_q, dmem_be_d;
    logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic              out_rd_we_q, out_rd_we_d;
    logic [1:0]        out_exc_q, out_exc_d;
    logic [2:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              ld_q, ld_d;

    logic              accept;
    logic [2:0]        funct3;
    logic [2:0]        off;
    logic [1:0]        sz;
    logic              misal;
    logic [7:0]        be_mask;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   ld_val;
    logic              unused_funct;

    assign unused_funct = ^op_ir[14:10];
    assign in_ready     = (state_q != REQ);
    assign accept       = in_valid && in_ready;
    assign funct3       = op_ir[9:7];
    assign off          = alu_out[2:0];
    assign sz           = funct3[1:0];

    always_comb begin
        misal   = 1'b0;
        be_mask = 8'h01;
        case (sz)
            2'd0: begin misal = 1'b0;        be_mask = 8'h01; end
            2'd1: begin misal = off[0];      be_mask = 8'h03; end
            2'd2: begin misal = |off[1:0];   be_mask = 8'h0F; end
            default: begin misal = |off;     be_mask = 8'hFF; end
        endcase
    end

    // Load data is extracted from the lanes remembered at accept time.
    always_comb begin
        shifted = dmem_rdata >> {off_q, 3'b000};
        ld_val  = shifted;
        case (size_q)
            2'd0: ld_val = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1: ld_val = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: ld_val = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            default: ld_val = shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_rd_we_d  = 1'b0;
        out_exc_d    = 2'd0;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        ld_d         = ld_q;

        if (state_q == REQ) begin
            if (dmem_ack) begin
                dmem_req_d  = 1'b0;
                state_d     = RESP;
                out_valid_d = 1'b1;
                out_rd_we_d = ld_q;
                out_data_d  = ld_q ? ld_val : '0;
            end
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end

        if (accept) begin
            state_d     = RESP;
            out_valid_d = 1'b1;
            out_data_d  = '0;
            if (op_ir[6:0] == OP_LOAD || op_ir[6:0] == OP_STORE) begin
                if ((op_ir[6:0] == OP_LOAD && funct3 == 3'd7) ||
                    (op_ir[6:0] == OP_STORE && funct3[2])) begin
                    out_exc_d = 2'd2;
                end else if (misal) begin
                    out_exc_d = 2'd1;
                end else begin
                    state_d      = REQ;
                    out_valid_d  = 1'b0;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = (op_ir[6:0] == OP_STORE);
                    dmem_addr_d  = {alu_out[XLEN-1:3], 3'b000};
                    dmem_be_d    = be_mask << off;
                    dmem_wdata_d = rs2 << {off, 3'b000};
                    off_d        = off;
                    size_d       = sz;
                    uns_d        = funct3[2];
                    ld_d         = (op_ir[6:0] == OP_LOAD);
                end
            end else if (op_ir[6:0] == OP_AMO) begin
                out_exc_d = 2'd2;
            end else begin
                out_data_d  = alu_out;
                out_rd_we_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= 8'd0;
            dmem_wdata_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_rd_we_q  <= 1'b0;
            out_exc_q    <= 2'd0;
            off_q        <= 3'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            ld_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_rd_we_q  <= out_rd_we_d;
            out_exc_q    <= out_exc_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            ld_q         <= ld_d;
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_rd_we  = out_rd_we_q;
    assign out_exc    = out_exc_q;
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized ops checked against a byte-level reference model.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] op_ir;
    logic [63:0] alu_out, rs2;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr;
    logic [7:0]  dmem_be;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_rd_we;
    logic [1:0]  out_exc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_ir(op_ir), .alu_out(alu_out), .rs2(rs2),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_data(out_data),
        .out_rd_we(out_rd_we), .out_exc(out_exc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] mk_op(input logic [2:0] f3, input logic [6:0] opc);
        return {5'd0, f3, opc};
    endfunction

    // Reference: byte-by-byte view of the access.
    task automatic model(input logic [14:0] op, input logic [63:0] a, d2, rd,
                         output bit mem, output bit we, output logic [7:0] be,
                         output logic [63:0] wdat, output logic [1:0] exc,
                         output bit rdwe, output logic [63:0] res);
        int f3, nb, off;
        logic [63:0] v;
        bit is_ld, is_st;
        f3 = int'(op[9:7]);
        nb = 1 << (f3 % 4);
        off = int'(a % 64'd8);
        is_ld = (op[6:0] == 7'b0000011);
        is_st = (op[6:0] == 7'b0100011);
        mem = 0; we = 0; be = 0; wdat = 0; exc = 0; rdwe = 0; res = 0;
        if (is_ld || is_st) begin
            if ((is_ld && f3 == 7) || (is_st && f3 >= 4)) exc = 2;
            else if (a % 64'(nb) != 0) exc = 1;
            else begin
                mem = 1;
                we = is_st;
                for (int i = 0; i < nb; i++) begin
                    be[off+i] = 1'b1;
                    wdat[8*(off+i) +: 8] = d2[8*i +: 8];
                end
                if (is_ld) begin
                    v = 0;
                    for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
                    if (f3 < 4 && nb < 8 && v[8*nb-1])
                        for (int j = 8*nb; j < 64; j++) v[j] = 1'b1;
                    res = v;
                    rdwe = 1;
                end
            end
        end else if (op[6:0] == 7'b0101111) begin
            exc = 2;
        end else begin
            rdwe = 1;
            res = a;
        end
    endtask

    task automatic run_op(input logic [14:0] op, input logic [63:0] a, d2, rd, input int waits);
        bit mem, we, rdwe;
        logic [7:0] be;
        logic [63:0] wdat, res, lane;
        logic [1:0] exc;
        int n;
        model(op, a, d2, rd, mem, we, be, wdat, exc, rdwe, res);
        lane = 0;
        for (int i = 0; i < 8; i++) if (be[i]) lane[8*i +: 8] = 8'hFF;
        op_ir = op; alu_out = a; rs2 = d2; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("req", 64'(dmem_req), 64'(mem));
        if (mem) begin
            chk("addr", dmem_addr, {a[63:3], 3'b000});
            chk("be", 64'(dmem_be), 64'(be));
            chk("we", 64'(dmem_we), 64'(we));
            if (we) chk("wdata", dmem_wdata & lane, wdat);
            for (int w = 0; w < waits; w++) begin
                step();
                chk("req_hold", 64'(dmem_req), 64'd1);
                chk("addr_hold", dmem_addr, {a[63:3], 3'b000});
                chk("no_vld", 64'(out_valid), 64'd0);
                chk("rdy_low", 64'(in_ready), 64'd0);
            end
            dmem_rdata = rd;
            dmem_ack = 1'b1;
            step();
            dmem_ack = 1'b0;
            dmem_rdata = {$urandom, $urandom};
            chk("req_drop", 64'(dmem_req), 64'd0);
        end
        chk("vld", 64'(out_valid), 64'd1);
        chk("exc", 64'(out_exc), 64'(exc));
        chk("rdwe", 64'(out_rd_we), 64'(rdwe));
        if (exc == 0) chk("data", out_data, res);
    endtask

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, AMO = 7'b0101111, ALU = 7'b0110011;

    initial begin
        logic [6:0] opcs [5];
        opcs[0] = LD; opcs[1] = ST; opcs[2] = AMO; opcs[3] = ALU; opcs[4] = 7'b0010011;
        rst = 1'b1; in_valid = 1'b0; op_ir = 0; alu_out = 0; rs2 = 0;
        dmem_ack = 1'b0; dmem_rdata = 0;
        step(); step();
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_be", 64'(dmem_be), 64'd0);
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd1);
        rst = 1'b0;
        step();

        // back-to-back pass-through
        run_op(mk_op(3'd0, ALU), 64'd5, 64'd0, 64'd0, 0);
        run_op(mk_op(3'd0, ALU), 64'd6, 64'd0, 64'd0, 0);
        run_op(mk_op(3'd0, ALU), 64'd7, 64'd0, 64'd0, 0);
        step();
        chk("idle_vld", 64'(out_valid), 64'd0);

        run_op(mk_op(3'd0, LD), 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 3);
        chk("lb_val", out_data, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(mk_op(3'd4, LD), 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 3);
        chk("lbu_val", out_data, 64'h80);
        run_op(mk_op(3'd1, ST), 64'h2006, 64'h1234, 64'd0, 1);
        run_op(mk_op(3'd2, LD), 64'h2002, 64'd0, 64'd0, 0);
        run_op(mk_op(3'd3, AMO), 64'h2000, 64'd0, 64'd0, 0);
        run_op(mk_op(3'd7, LD), 64'h2000, 64'd0, 64'd0, 0);
        run_op(mk_op(3'd4, ST), 64'h2000, 64'd0, 64'd0, 0);
        step();

        // reset in the second REQ cycle, then a stray ack
        op_ir = mk_op(3'd3, LD); alu_out = 64'h4000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rq1", 64'(dmem_req), 64'd1);
        step();
        chk("rq2", 64'(dmem_req), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_req", 64'(dmem_req), 64'd0);
        chk("rst_mid_rdy", 64'(in_ready), 64'd1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("stray_vld0", 64'(out_valid), 64'd0);
        step();
        chk("stray_vld1", 64'(out_valid), 64'd0);

        // LD with ack in first REQ cycle; next op held during REQ
        op_ir = mk_op(3'd3, LD); alu_out = 64'h3000; in_valid = 1'b1;
        step();
        op_ir = mk_op(3'd0, ALU); alu_out = 64'h55;
        chk("req_rdy_low", 64'(in_ready), 64'd0);
        dmem_rdata = 64'hDEADBEEF_01234567; dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("ld_vld", 64'(out_valid), 64'd1);
        chk("ld_val", out_data, 64'hDEADBEEF_01234567);
        chk("resp_rdy", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("pt_vld", 64'(out_valid), 64'd1);
        chk("pt_val", out_data, 64'h55);
        step();
        chk("end_vld", 64'(out_valid), 64'd0);
        chk("end_exc", 64'(out_exc), 64'd0);

        for (int k = 0; k < 300; k++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
            run_op(mk_op(3'($urandom_range(0, 7)), opcs[$urandom_range(0, 4)]),
                   a, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                step();
                chk("gap_vld", 64'(out_valid), 64'd0);
                chk("gap_exc", 64'(out_exc), 64'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
